// File: rtl/fifo_memu.sv
// Storage block for the accumulator: a first-word-fall-through input FIFO and
// a partial-sum memory with a synchronous write port and a combinational read port.
module fifo_memu #(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int NUM_SLOTS       = 4,
    parameter int LOG_NUM_SLOTS   = 2,
    parameter int MEM_DATA_WIDTH  = 32,
    parameter int NUM_ADDRESSES   = 1024,
    parameter int LOG_MAX_ADDRESS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FIFO_DATA_WIDTH-1:0] data_write,
    input  logic                       write,
    output logic                       full,
    output logic                       almost_full,
    output logic [FIFO_DATA_WIDTH-1:0] data_read,
    input  logic                       next_read,
    output logic                       empty,
    input  logic [MEM_DATA_WIDTH-1:0]  mem_data_write,
    input  logic [LOG_MAX_ADDRESS-1:0] mem_addr_write,
    input  logic                       mem_write,
    input  logic [LOG_MAX_ADDRESS-1:0] mem_addr_read,
    output logic [MEM_DATA_WIDTH-1:0]  mem_data_read
);

    localparam int LOG_NUM_ADDRESSES = (NUM_ADDRESSES > 1) ? $clog2(NUM_ADDRESSES) : 1;
    localparam logic [LOG_NUM_SLOTS:0] FULL_COUNT = (LOG_NUM_SLOTS+1)'(NUM_SLOTS);

    logic [FIFO_DATA_WIDTH-1:0] slots [NUM_SLOTS];
    logic [LOG_NUM_SLOTS-1:0]   rd_ptr;
    logic [LOG_NUM_SLOTS-1:0]   wr_ptr;
    logic [LOG_NUM_SLOTS:0]     count;
    logic                       push;
    logic                       pop;

    logic [MEM_DATA_WIDTH-1:0]  mem [NUM_ADDRESSES];
    logic                       write_in_range;
    logic                       read_in_range;

    // Acceptance is judged on the registered flags, so a push while full is
    // dropped even when a pop frees a slot in the same cycle.
    assign push = write && !full;
    assign pop  = next_read && !empty;

    assign empty       = (count == '0);
    assign full        = (count == FULL_COUNT);
    assign almost_full = (count == FULL_COUNT - 1'b1);
    assign data_read   = empty ? '0 : slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Slot contents need no reset; data_read is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst && push) slots[wr_ptr] <= data_write;
    end

    assign write_in_range = (32'(mem_addr_write) < NUM_ADDRESSES);
    assign read_in_range  = (32'(mem_addr_read) < NUM_ADDRESSES);

    // Memory ignores reset entirely: contents persist and writes still land.
    always_ff @(posedge clk) begin
        if (mem_write && write_in_range)
            mem[mem_addr_write[LOG_NUM_ADDRESSES-1:0]] <= mem_data_write;
    end

    assign mem_data_read = read_in_range ? mem[mem_addr_read[LOG_NUM_ADDRESSES-1:0]] : '0;

endmodule

// File: tb/tb_fifo_memu.sv
// Randomized and directed checks of fifo_memu against a queue-based FIFO model
// and an associative-array memory model.
module tb_fifo_memu;

    localparam int FW    = 32;
    localparam int SLOTS = 4;
    localparam int MW    = 32;
    localparam int NADDR = 1024;
    localparam int AW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [FW-1:0] data_write = '0;
    logic          write = 1'b0;
    logic          full;
    logic          almost_full;
    logic [FW-1:0] data_read;
    logic          next_read = 1'b0;
    logic          empty;
    logic [MW-1:0] mem_data_write = '0;
    logic [AW-1:0] mem_addr_write = '0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] mem_addr_read = '0;
    logic [MW-1:0] mem_data_read;

    int errors = 0;
    int checks = 0;

    logic [FW-1:0] q [$];
    logic [MW-1:0] mem_model [int];

    fifo_memu #(
        .FIFO_DATA_WIDTH(FW), .NUM_SLOTS(SLOTS), .LOG_NUM_SLOTS(2),
        .MEM_DATA_WIDTH(MW), .NUM_ADDRESSES(NADDR), .LOG_MAX_ADDRESS(AW)
    ) dut (
        .clk(clk), .rst(rst), .data_write(data_write), .write(write),
        .full(full), .almost_full(almost_full), .data_read(data_read),
        .next_read(next_read), .empty(empty),
        .mem_data_write(mem_data_write), .mem_addr_write(mem_addr_write),
        .mem_write(mem_write), .mem_addr_read(mem_addr_read),
        .mem_data_read(mem_data_read)
    );

    always #5 clk = ~clk;

    // Expected {empty, almost_full, full, data_read} from the model queue.
    function automatic logic [FW+2:0] exp_status();
        logic [FW-1:0] head;
        head = (q.size() == 0) ? '0 : q[0];
        return {q.size() == 0, q.size() == SLOTS - 1, q.size() == SLOTS, head};
    endfunction

    // One clock edge: update the models from the inputs in force, then settle.
    task automatic cycle();
        bit push_ok, pop_ok;
        if (mem_write && int'(mem_addr_write) < NADDR)
            mem_model[int'(mem_addr_write)] = mem_data_write;
        if (!rst) begin
            q.delete();
        end else begin
            push_ok = write && q.size() < SLOTS;
            pop_ok  = next_read && q.size() > 0;
            if (pop_ok)  void'(q.pop_front());
            if (push_ok) q.push_back(data_write);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input logic [FW-1:0] d, input bit r);
        write = w;
        data_write = d;
        next_read = r;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1, 32'hBAD0_0001, 1);
        cycle();
        cycle();
        rst = 1'b1;
        drive(0, 0, 0);
        cycle();
        checks++;
        if ({empty, almost_full, full, data_read} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL reset_state: got e=%b af=%b f=%b d=%h, want e=1 af=0 f=0 d=0",
                     empty, almost_full, full, data_read);
        end
    endtask

    task automatic test_fill_drain();
        logic [FW-1:0] pushes [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        logic [FW-1:0] order  [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 5; i++) begin
            drive(1, pushes[i], 0);
            cycle();
            checks++;
            if ({empty, almost_full, full, data_read} !== exp_status()) begin
                errors++;
                $display("[TB] FAIL fill_%0d: got {e,af,f,d}=%h, want %h", i,
                         {empty, almost_full, full, data_read}, exp_status());
            end
        end
        checks++;
        if ({almost_full, full, data_read} !== {1'b0, 1'b1, 32'h11}) begin
            errors++;
            $display("[TB] FAIL full_after_drop: got af=%b f=%b d=%h, want af=0 f=1 d=11",
                     almost_full, full, data_read);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_read !== order[i]) begin
                errors++;
                $display("[TB] FAIL drain_%0d: got %h, want %h", i, data_read, order[i]);
            end
            drive(0, 0, 1);
            cycle();
        end
        drive(0, 0, 0);
        checks++;
        if ({empty, almost_full, full, data_read} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL drained_empty: got e=%b af=%b f=%b d=%h, want e=1 af=0 f=0 d=0",
                     empty, almost_full, full, data_read);
        end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] expected [$];
        expected = '{32'hA1, 32'hA2};
        drive(1, 32'hA1, 0); cycle();
        drive(1, 32'hA2, 0); cycle();
        for (int i = 1; i <= 10; i++) expected.push_back(FW'(i));
        for (int i = 1; i <= 10; i++) begin
            checks++;
            if (data_read !== expected[i-1]) begin
                errors++;
                $display("[TB] FAIL b2b_pop_%0d: got %h, want %h", i, data_read, expected[i-1]);
            end
            drive(1, FW'(i), 1);
            cycle();
            checks++;
            if ({empty, almost_full, full} !== 3'b000 || q.size() != 2) begin
                errors++;
                $display("[TB] FAIL b2b_flags_%0d: got e=%b af=%b f=%b, want 000", i,
                         empty, almost_full, full);
            end
        end
        drive(0, 0, 1); cycle();
        drive(0, 0, 1); cycle();
        drive(0, 0, 0);
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_drain: got empty=%b, want 1", empty);
        end
    endtask

    task automatic test_empty_corner();
        drive(0, 0, 1);
        cycle();
        checks++;
        if ({empty, almost_full, full, data_read} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL pop_empty: got e=%b af=%b f=%b d=%h, want e=1 af=0 f=0 d=0",
                     empty, almost_full, full, data_read);
        end
        drive(1, 32'h0000_0077, 1);
        cycle();
        drive(0, 0, 0);
        checks++;
        if ({empty, data_read} !== {1'b0, 32'h77} || q.size() != 1) begin
            errors++;
            $display("[TB] FAIL pushpop_empty: got e=%b d=%h, want e=0 d=77", empty, data_read);
        end
        drive(0, 0, 1); cycle();
        drive(0, 0, 1); cycle();
        drive(0, 0, 0);
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_pop: got empty=%b, want 1", empty);
        end
    endtask

    task automatic test_memory();
        mem_write = 1; mem_addr_write = 5; mem_data_write = 32'hDEADBEEF;
        cycle();
        mem_write = 0; mem_addr_read = 5;
        #1;
        checks++;
        if (mem_data_read !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL mem_read5: got %h, want deadbeef", mem_data_read);
        end
        mem_write = 1; mem_addr_write = 5; mem_data_write = 32'h1;
        #1;
        checks++;
        if (mem_data_read !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL mem_rdw_old: got %h, want deadbeef", mem_data_read);
        end
        cycle();
        mem_write = 0;
        checks++;
        if (mem_data_read !== 32'h1) begin
            errors++;
            $display("[TB] FAIL mem_rdw_new: got %h, want 00000001", mem_data_read);
        end
        mem_write = 1; mem_addr_write = AW'(NADDR + 5); mem_data_write = 32'hFFFF_0000;
        cycle();
        mem_write = 0;
        checks++;
        if (mem_data_read !== 32'h1) begin
            errors++;
            $display("[TB] FAIL mem_oob_write: got %h, want 00000001", mem_data_read);
        end
        mem_addr_read = AW'(NADDR);
        #1;
        checks++;
        if (mem_data_read !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mem_oob_read: got %h, want 0", mem_data_read);
        end
        mem_addr_read = 5;
    endtask

    task automatic test_random();
        int r;
        logic [MW-1:0] exp_mem;
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 9) < 5));
            mem_write = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            mem_addr_write = (r == 0) ? AW'(NADDR + $urandom_range(0, 15)) : AW'($urandom_range(0, 15));
            mem_data_write = $urandom;
            r = $urandom_range(0, 9);
            mem_addr_read = (r == 0) ? AW'($urandom_range(NADDR, 65535)) : AW'($urandom_range(0, 15));
            #1;
            if (int'(mem_addr_read) >= NADDR || mem_model.exists(int'(mem_addr_read))) begin
                exp_mem = (int'(mem_addr_read) >= NADDR) ? '0 : mem_model[int'(mem_addr_read)];
                checks++;
                if (mem_data_read !== exp_mem) begin
                    errors++;
                    $display("[TB] FAIL rand_mem_%0d: addr %0d got %h, want %h", i,
                             mem_addr_read, mem_data_read, exp_mem);
                end
            end
            cycle();
            checks++;
            if ({empty, almost_full, full, data_read} !== exp_status()) begin
                errors++;
                $display("[TB] FAIL rand_fifo_%0d: got {e,af,f,d}=%h, want %h", i,
                         {empty, almost_full, full, data_read}, exp_status());
            end
        end
        drive(0, 0, 0);
        mem_write = 0;
    endtask

    task automatic test_mid_reset();
        rst = 1'b0; cycle(); rst = 1'b1;
        mem_write = 1; mem_addr_write = 5; mem_data_write = 32'h1;
        drive(1, 32'hC1, 0); cycle();
        mem_write = 0;
        drive(1, 32'hC2, 0); cycle();
        drive(1, 32'hC3, 0); cycle();
        checks++;
        if ({empty, almost_full, data_read} !== {1'b0, 1'b1, 32'hC1}) begin
            errors++;
            $display("[TB] FAIL pre_reset: got e=%b af=%b d=%h, want e=0 af=1 d=c1",
                     empty, almost_full, data_read);
        end
        rst = 1'b0;
        drive(1, 32'hC4, 1);
        mem_write = 1; mem_addr_write = 9; mem_data_write = 32'h9999;
        cycle();
        rst = 1'b1;
        drive(0, 0, 0);
        mem_write = 0;
        checks++;
        if ({empty, almost_full, full, data_read} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL mid_reset: got e=%b af=%b f=%b d=%h, want e=1 af=0 f=0 d=0",
                     empty, almost_full, full, data_read);
        end
        mem_addr_read = 5;
        #1;
        checks++;
        if (mem_data_read !== 32'h1) begin
            errors++;
            $display("[TB] FAIL mem_keep: got %h, want 00000001", mem_data_read);
        end
        mem_addr_read = 9;
        #1;
        checks++;
        if (mem_data_read !== 32'h9999) begin
            errors++;
            $display("[TB] FAIL mem_write_in_reset: got %h, want 00009999", mem_data_read);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_empty_corner();
        test_memory();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
